// File: rtl/taito_serial_pkg.sv
// Shared definitions for the dual-channel serial shifter/deserializer pair.
// Word width default and the frame FSM state encoding live here.
package taito_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/s2p_lane.sv
// One deserializer lane: a direction-selectable shift register feeding
// a holding register that captures the completed word on the final bit.
module s2p_lane
  import taito_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             flush,
  input  logic             load,
  input  logic             rev,
  input  logic             din,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  // The word loaded on the final edge must already contain that edge's bit,
  // so the holding register takes the shifted value, not the current one.
  always_comb begin
    sr_next = sr;
    if (rev) sr_next = {din, sr[WIDTH-1:1]};
    else     sr_next = {sr[WIDTH-2:0], din};
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in the design samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sr   <= '0;
      data <= '0;
    end else begin
      if (flush)         sr <= '0;
      else if (shift_en) sr <= sr_next;
      if (load) data <= sr_next;
    end
  end

endmodule

// File: rtl/mb112_s2p_deserializer.sv
// Dual-channel serial-to-parallel receiver, cycle-compatible with the
// parallel-to-serial shifter; words are handed off with valid/ack.
module mb112_s2p_deserializer
  import taito_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start_n,
  input  logic             reverse,
  input  logic             in1,
  input  logic             in2,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic             data_valid,
  input  logic             data_ack,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rev_q;

  logic in_shift;
  logic last_bit;
  logic start_req;
  logic restart;
  logic shift_en;
  logic load;
  logic ovr_event;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    in_shift  = (state == SHIFT);
    last_bit  = (cnt == CW'(WIDTH - 1));
    start_req = !start_n;
    restart   = in_shift && !last_bit && start_req;
    shift_en  = in_shift && !restart;
    load      = in_shift && last_bit;
    ovr_event = load && data_valid && !data_ack;
  end

  // A strobe on the final edge chains straight into the next frame; a strobe
  // on any earlier edge throws the partial word away.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      cnt   <= '0;
      rev_q <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            rev_q <= reverse;
          end
        end
        SHIFT: begin
          if (start_req) begin
            cnt   <= '0;
            rev_q <= reverse;
          end else if (last_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A completion always wins over an ack; overrun only records a word lost
  // while the consumer was not acknowledging.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= load || (data_valid && !data_ack);
      overrun    <= ovr_event || (overrun && !data_ack);
    end
  end

  s2p_lane #(.WIDTH(WIDTH)) u_lane1 (
    .clk      (clk),
    .clear    (clear),
    .shift_en (shift_en),
    .flush    (start_req),
    .load     (load),
    .rev      (rev_q),
    .din      (in1),
    .data     (data1)
  );

  s2p_lane #(.WIDTH(WIDTH)) u_lane2 (
    .clk      (clk),
    .clear    (clear),
    .shift_en (shift_en),
    .flush    (start_req),
    .load     (load),
    .rev      (rev_q),
    .din      (in2),
    .data     (data2)
  );

endmodule

// File: tb/tb_mb112_s2p_deserializer.sv
// Self-checking bench: expected word pairs are queued as frames are driven
// and popped by a monitor that acknowledges each delivered word.
module tb_mb112_s2p_deserializer;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       start_n = 1'b1;
  logic       reverse = 1'b0;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic       mon_ack = 1'b0;
  logic       man_ack = 1'b0;
  logic       data_ack;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  bit          mon_en = 1'b0;

  assign data_ack = mon_ack | man_ack;

  always #5 clk = ~clk;

  mb112_s2p_deserializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .clear      (clear),
    .start_n    (start_n),
    .reverse    (reverse),
    .in1        (in1),
    .in2        (in2),
    .data1      (data1),
    .data2      (data2),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: each newly valid word is compared with the oldest queued pair, then acked.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && data_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_word", {16'h0, data1, data2}, 32'hFFFF_FFFF);
        end else begin
          check("sb_word", {16'h0, data1, data2}, {16'h0, sb.pop_front()});
        end
        check("sb_overrun", {31'h0, overrun}, 32'h0);
        mon_ack = 1'b1;
        @(negedge clk);
        mon_ack = 1'b0;
      end
    end
  end

  task automatic start_pulse(input bit rev);
    start_n = 1'b0;
    reverse = rev;
    @(negedge clk);
  endtask

  // Drives one frame's 8 bits; optionally strobes the next start on the last bit.
  task automatic shift_bits(input logic [7:0] w1, input logic [7:0] w2, input bit rev,
                            input bit push, input bit flip_rev, input bit chain,
                            input bit next_rev, input bit ack_last);
    if (push) sb.push_back({w1, w2});
    for (int n = 0; n < 8; n++) begin
      in1     = rev ? w1[n] : w1[7-n];
      in2     = rev ? w2[n] : w2[7-n];
      start_n = !(chain && n == 7);
      if (chain && n == 7)      reverse = next_rev;
      else if (flip_rev && n >= 3) reverse = ~rev;
      man_ack = ack_last && (n == 7);
      @(negedge clk);
    end
    start_n = 1'b1;
    man_ack = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_data1", {24'h0, data1}, 32'h0);
    check("rst_data2", {24'h0, data2}, 32'h0);
    check("rst_flags", {29'h0, data_valid, busy, overrun}, 32'h0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // MSB-first frame
    start_pulse(1'b0);
    check("msb_busy_start", {31'h0, busy}, 32'h1);
    shift_bits(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("msb_valid", {31'h0, data_valid}, 32'h1);
    check("msb_busy_end", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);

    // LSB-first, reverse toggled mid-frame must not matter
    start_pulse(1'b1);
    shift_bits(8'hA5, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Loopback: back-to-back frames, busy held between them
    start_pulse(1'b0);
    shift_bits(8'h12, 8'h34, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("loop_busy1", {31'h0, busy}, 32'h1);
    shift_bits(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("loop_busy2", {31'h0, busy}, 32'h1);
    shift_bits(8'h80, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("loop_busy3", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);

    // Restart after 3 bits: partial word must never surface
    start_pulse(1'b0);
    for (int n = 0; n < 3; n++) begin
      start_n = 1'b1;
      in1 = 1'b1;
      in2 = 1'b0;
      @(negedge clk);
    end
    check("restart_novalid", {31'h0, data_valid}, 32'h0);
    start_pulse(1'b0);
    shift_bits(8'hC3, 8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    // Overrun: two words with no ack
    mon_en = 1'b0;
    @(negedge clk);
    start_pulse(1'b0);
    shift_bits(8'h11, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_first_flag", {31'h0, overrun}, 32'h0);
    start_pulse(1'b0);
    shift_bits(8'h33, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_word", {16'h0, data1, data2}, 32'h3344);
    check("ovr_flags", {30'h0, data_valid, overrun}, 32'h3);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("ack_flags", {30'h0, data_valid, overrun}, 32'h0);
    check("ack_keep_word", {16'h0, data1, data2}, 32'h3344);

    // Ack coinciding with a completion
    start_pulse(1'b0);
    shift_bits(8'h55, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start_pulse(1'b0);
    shift_bits(8'h77, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("coinc_word", {16'h0, data1, data2}, 32'h7788);
    check("coinc_flags", {30'h0, data_valid, overrun}, 32'h2);

    // Async clear mid-frame, between clock edges
    start_pulse(1'b0);
    for (int n = 0; n < 4; n++) begin
      start_n = 1'b1;
      in1 = n[0];
      in2 = 1'b1;
      @(negedge clk);
    end
    #2 clear = 1'b0;
    #1;
    check("clr_data1", {24'h0, data1}, 32'h0);
    check("clr_data2", {24'h0, data2}, 32'h0);
    check("clr_flags", {29'h0, data_valid, busy, overrun}, 32'h0);
    #1 clear = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    start_pulse(1'b0);
    shift_bits(8'h5A, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
